// File: rtl/edgcol_pkg.sv
// Shared types and default sizes for the edge-collection register bank.
package edgcol_pkg;

  localparam int REG_WIDTH_DEF   = 32;
  localparam int NUM_ENTRIES_DEF = 6;
  localparam int ADDR_WIDTH_DEF  = 3;

  // Serial read-out state machine.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } strm_state_e;

endpackage

// File: rtl/edgcol_register_bank_if.sv
// Write, parallel-read and stream read-out signals of the edge register bank.
interface edgcol_register_bank_if
  import edgcol_pkg::*;
#(
  parameter int REG_WIDTH   = REG_WIDTH_DEF,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) ();

  logic                             clr;
  logic                             wrEna;
  logic                             wrMode;
  logic [ADDR_WIDTH-1:0]            wrAddr;
  logic [REG_WIDTH-1:0]             wrData;
  logic                             wrErr;
  logic [NUM_ENTRIES*REG_WIDTH-1:0] rdData;
  logic [NUM_ENTRIES-1:0]           validMask;
  logic [ADDR_WIDTH:0]              count;
  logic                             full;
  logic                             strmStart;
  logic                             strmValid;
  logic                             strmReady;
  logic [REG_WIDTH-1:0]             strmData;
  logic [ADDR_WIDTH-1:0]            strmIdx;
  logic                             strmLast;

  modport master (
    output clr, wrEna, wrMode, wrAddr, wrData, strmStart, strmReady,
    input  wrErr, rdData, validMask, count, full, strmValid, strmData, strmIdx, strmLast
  );

  modport slave (
    input  clr, wrEna, wrMode, wrAddr, wrData, strmStart, strmReady,
    output wrErr, rdData, validMask, count, full, strmValid, strmData, strmIdx, strmLast
  );

endinterface

// File: rtl/edgcol_first_valid.sv
// Priority search: lowest set mask bit whose index is at or above start_i.
// start_i is one bit wider than an index so "past the last entry" is expressible.
module edgcol_first_valid
  import edgcol_pkg::*;
#(
  parameter int N  = NUM_ENTRIES_DEF,
  parameter int IW = ADDR_WIDTH_DEF
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW:0]   start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic hit_s;

  // Scan upward; the first qualifying bit wins and later hits are masked off.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      hit_s   = mask_i[i] && (i >= int'(start_i)) && !found_o;
      idx_o   = hit_s ? IW'(i) : idx_o;
      found_o = found_o | hit_s;
    end
  end

endmodule

// File: rtl/edgcol_register_bank.sv
// Edge-collection register bank: addressed/append writes, parallel read,
// and a snapshot-based serial read-out of the valid entries.
module edgcol_register_bank
  import edgcol_pkg::*;
#(
  parameter int REG_WIDTH   = REG_WIDTH_DEF,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   rst,
  edgcol_register_bank_if.slave bus
);

  logic [REG_WIDTH-1:0]   data_q [NUM_ENTRIES];
  logic [REG_WIDTH-1:0]   data_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] snap_q, snap_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   full_q, full_d;
  logic                   wr_err_q, wr_err_d;
  strm_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;

  logic                   wr_hit_s;
  logic [ADDR_WIDTH-1:0]  wr_idx_s;
  logic [ADDR_WIDTH-1:0]  app_idx_s, first_idx_s, nxt_idx_s;
  logic                   app_found_s, first_found_s, nxt_found_s;
  logic [REG_WIDTH-1:0]   strm_data_s;

  // Lowest free slot for append writes.
  edgcol_first_valid #(.N(NUM_ENTRIES), .IW(ADDR_WIDTH)) u_app_sel (
    .mask_i(~valid_q), .start_i('0), .idx_o(app_idx_s), .found_o(app_found_s)
  );

  // Lowest valid entry: first beat of a new stream (found == count>0).
  edgcol_first_valid #(.N(NUM_ENTRIES), .IW(ADDR_WIDTH)) u_first_sel (
    .mask_i(valid_q), .start_i('0), .idx_o(first_idx_s), .found_o(first_found_s)
  );

  // Next snapshot entry above the current beat; none found means last beat.
  edgcol_first_valid #(.N(NUM_ENTRIES), .IW(ADDR_WIDTH)) u_next_sel (
    .mask_i(snap_q), .start_i({1'b0, idx_q} + (ADDR_WIDTH+1)'(1)),
    .idx_o(nxt_idx_s), .found_o(nxt_found_s)
  );

  // Write decode: clr drops any write, out-of-range or full writes are rejected.
  always_comb begin
    valid_d  = valid_q;
    wr_err_d = 1'b0;
    wr_hit_s = 1'b0;
    wr_idx_s = '0;
    if (bus.clr) begin
      valid_d = '0;
    end else if (bus.wrEna) begin
      if (bus.wrMode == 1'b0) begin
        if (int'(bus.wrAddr) < NUM_ENTRIES) begin
          wr_hit_s = 1'b1;
          wr_idx_s = bus.wrAddr;
        end else begin
          wr_err_d = 1'b1;
        end
      end else begin
        if (app_found_s) begin
          wr_hit_s = 1'b1;
          wr_idx_s = app_idx_s;
        end else begin
          wr_err_d = 1'b1;
        end
      end
    end else begin
      wr_hit_s = 1'b0;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (wr_hit_s && (int'(wr_idx_s) == i)) begin
        data_d[i]  = bus.wrData;
        valid_d[i] = 1'b1;
      end else begin
        data_d[i]  = data_q[i];
      end
    end
  end

  // Occupancy status computed from the next valid mask so it updates with it.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      count_d = count_d + (ADDR_WIDTH+1)'(valid_d[i]);
    end
    full_d = &valid_d;
  end

  // Stream FSM next state: snapshot on start, skip invalid entries on transfer.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    if (bus.clr) begin
      state_d = IDLE;
      snap_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.strmStart && first_found_s) begin
            state_d = STREAM;
            snap_d  = valid_q;
            idx_d   = first_idx_s;
          end else begin
            state_d = IDLE;
          end
        end
        STREAM: begin
          if (bus.strmReady) begin
            if (!nxt_found_s) begin
              state_d = IDLE;
              snap_d  = '0;
              idx_d   = '0;
            end else begin
              idx_d   = nxt_idx_s;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = IDLE;
          snap_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Live read of the entry addressed by the current beat.
  always_comb begin
    strm_data_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      strm_data_s = (int'(idx_q) == i) ? data_q[i] : strm_data_s;
    end
  end

  // State registers; reset clears everything including the data array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      snap_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      wr_err_q <= 1'b0;
      state_q  <= IDLE;
      idx_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q  <= valid_d;
      snap_q   <= snap_d;
      count_q  <= count_d;
      full_q   <= full_d;
      wr_err_q <= wr_err_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_rd
    assign bus.rdData[g*REG_WIDTH +: REG_WIDTH] = data_q[g];
  end

  assign bus.validMask = valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.wrErr     = wr_err_q;
  assign bus.strmValid = (state_q == STREAM);
  assign bus.strmIdx   = idx_q;
  assign bus.strmLast  = (state_q == STREAM) && !nxt_found_s;
  assign bus.strmData  = strm_data_s;

endmodule

// File: tb/tb_edgcol_register_bank.sv
// Bench for edgcol_register_bank: write-vector table plus stream scoreboard.
module tb_edgcol_register_bank;
  import edgcol_pkg::*;

  localparam int RW = 32;
  localparam int NE = 6;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edgcol_register_bank_if #(.REG_WIDTH(RW), .NUM_ENTRIES(NE), .ADDR_WIDTH(AW)) bus ();

  edgcol_register_bank #(.REG_WIDTH(RW), .NUM_ENTRIES(NE), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic          clr, ena, mode;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic          err;
    logic [NE-1:0] mask;
    logic [AW:0]   cnt;
    logic          full;
    int            ci;
    logic [RW-1:0] cd;
  } vec_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [RW-1:0] data;
    logic          last;
  } beat_t;

  vec_t  vecs[16];
  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  function automatic vec_t mk(input logic c, input logic e, input logic m, input logic [AW-1:0] a,
                              input logic [RW-1:0] d, input logic er, input logic [NE-1:0] mk_m,
                              input logic [AW:0] cn, input logic f, input int ci, input logic [RW-1:0] cd);
    vec_t v;
    v.clr = c; v.ena = e; v.mode = m; v.addr = a; v.data = d; v.err = er;
    v.mask = mk_m; v.cnt = cn; v.full = f; v.ci = ci; v.cd = cd;
    return v;
  endfunction

  function automatic beat_t bt(input logic [AW-1:0] i, input logic [RW-1:0] d, input logic l);
    beat_t b;
    b.idx = i; b.data = d; b.last = l;
    return b;
  endfunction

  function automatic logic [RW-1:0] entry(input int i);
    return bus.rdData[i*RW +: RW];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.clr = 1'b0; bus.wrEna = 1'b0; bus.wrMode = 1'b0; bus.wrAddr = '0;
    bus.wrData = '0; bus.strmStart = 1'b0; bus.strmReady = 1'b0;
  endtask

  // Compare the beat currently presented against the oldest expected beat.
  task automatic pop_cmp(input string nm);
    beat_t b;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected beat: got idx %0d, expected no beat", nm, bus.strmIdx);
    end else begin
      b = sb.pop_front();
      chk({nm, " idx"},  64'(bus.strmIdx),  64'(b.idx));
      chk({nm, " data"}, 64'(bus.strmData), 64'(b.data));
      chk({nm, " last"}, 64'(bus.strmLast), 64'(b.last));
    end
  endtask

  // Consume beats with strmReady high; a gap after the first beat is an error.
  task automatic drain(input string nm, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && sb.size() != 0; c++) begin
      @(negedge clk);
      bus.strmStart = 1'b0;
      if (bus.strmValid && bus.strmReady) begin
        pop_cmp(nm);
        seen = 1'b1;
      end else if (seen) begin
        chk({nm, " bubble"}, 64'(bus.strmValid), 64'd1);
      end
    end
    chk({nm, " drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wr(input logic m, input logic [AW-1:0] a, input logic [RW-1:0] d);
    bus.wrEna = 1'b1; bus.wrMode = m; bus.wrAddr = a; bus.wrData = d;
    @(negedge clk);
    bus.wrEna = 1'b0;
  endtask

  task automatic setup_134();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    wr(1'b0, 3'd1, 32'd21);
    wr(1'b0, 3'd3, 32'd23);
    wr(1'b0, 3'd4, 32'd24);
    chk("setup mask",  64'(bus.validMask), 64'(6'b011010));
    chk("setup count", 64'(bus.count),     64'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd10, 1'b0, 6'b000001, 4'd1, 1'b0, 0, 32'd10);
    vecs[1]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd11, 1'b0, 6'b000011, 4'd2, 1'b0, 1, 32'd11);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd12, 1'b0, 6'b000111, 4'd3, 1'b0, 2, 32'd12);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd13, 1'b0, 6'b001111, 4'd4, 1'b0, 3, 32'd13);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd14, 1'b0, 6'b011111, 4'd5, 1'b0, 4, 32'd14);
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd15, 1'b0, 6'b111111, 4'd6, 1'b1, 5, 32'd15);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd16, 1'b1, 6'b111111, 4'd6, 1'b1, 0, 32'd10);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 32'd0,  1'b0, 6'b000000, 4'd0, 1'b0, 3, 32'd13);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 32'd7,  1'b0, 6'b000100, 4'd1, 1'b0, 2, 32'd7);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 3'd6, 32'd9,  1'b1, 6'b000100, 4'd1, 1'b0, 2, 32'd7);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 3'd7, 32'd1,  1'b1, 6'b000100, 4'd1, 1'b0, 5, 32'd15);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 3'd2, 32'd8,  1'b0, 6'b000100, 4'd1, 1'b0, 2, 32'd8);
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 3'd0, 32'd5,  1'b0, 6'b000000, 4'd0, 1'b0, 0, 32'd10);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd5,  1'b0, 6'b000001, 4'd1, 1'b0, 0, 32'd5);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 3'd5, 32'd55, 1'b0, 6'b100001, 4'd2, 1'b0, 5, 32'd55);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 3'd0, 32'd6,  1'b0, 6'b100011, 4'd3, 1'b0, 1, 32'd6);

    idle_inputs();
    #2 rst = 1'b0;
    #10;
    chk("rst mask",   64'(bus.validMask),     64'd0);
    chk("rst count",  64'(bus.count),         64'd0);
    chk("rst full",   64'(bus.full),          64'd0);
    chk("rst wrErr",  64'(bus.wrErr),         64'd0);
    chk("rst valid",  64'(bus.strmValid),     64'd0);
    chk("rst last",   64'(bus.strmLast),      64'd0);
    chk("rst idx",    64'(bus.strmIdx),       64'd0);
    chk("rst rdData", 64'(bus.rdData == '0),  64'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) begin
      bus.clr = vecs[k].clr; bus.wrEna = vecs[k].ena; bus.wrMode = vecs[k].mode;
      bus.wrAddr = vecs[k].addr; bus.wrData = vecs[k].data;
      @(negedge clk);
      chk($sformatf("vec%0d wrErr", k), 64'(bus.wrErr),         64'(vecs[k].err));
      chk($sformatf("vec%0d mask", k),  64'(bus.validMask),     64'(vecs[k].mask));
      chk($sformatf("vec%0d count", k), 64'(bus.count),         64'(vecs[k].cnt));
      chk($sformatf("vec%0d full", k),  64'(bus.full),          64'(vecs[k].full));
      chk($sformatf("vec%0d entry", k), 64'(entry(vecs[k].ci)), 64'(vecs[k].cd));
    end
    idle_inputs();

    // Uninterrupted stream over entries 1,3,4.
    setup_134();
    bus.strmReady = 1'b1;
    bus.strmStart = 1'b1;
    sb.push_back(bt(3'd1, 32'd21, 1'b0));
    sb.push_back(bt(3'd3, 32'd23, 1'b0));
    sb.push_back(bt(3'd4, 32'd24, 1'b1));
    drain("s1", 10);
    @(negedge clk);
    chk("s1 idle", 64'(bus.strmValid), 64'd0);

    // Stalled second beat, append and ignored start during the stream.
    bus.strmStart = 1'b1;
    sb.push_back(bt(3'd1, 32'd21, 1'b0));
    sb.push_back(bt(3'd3, 32'd23, 1'b0));
    sb.push_back(bt(3'd4, 32'd24, 1'b1));
    @(negedge clk);
    bus.strmStart = 1'b0;
    chk("s2 v1", 64'(bus.strmValid), 64'd1);
    pop_cmp("s2 b1");
    @(negedge clk);
    bus.strmReady = 1'b0;
    bus.strmStart = 1'b1;
    bus.wrEna = 1'b1; bus.wrMode = 1'b1; bus.wrData = 32'd30;
    chk("s2 hold idx", 64'(bus.strmIdx), 64'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.wrEna = 1'b0;
      bus.strmStart = 1'b0;
      chk($sformatf("s2 stall%0d valid", k), 64'(bus.strmValid), 64'd1);
      chk($sformatf("s2 stall%0d idx", k),   64'(bus.strmIdx),   64'd3);
      chk($sformatf("s2 stall%0d data", k),  64'(bus.strmData),  64'd23);
    end
    bus.strmReady = 1'b1;
    pop_cmp("s2 b2");
    drain("s2 tail", 5);
    @(negedge clk);
    chk("s2 idle",    64'(bus.strmValid), 64'd0);
    chk("s2 mask",    64'(bus.validMask), 64'(6'b011011));
    chk("s2 count",   64'(bus.count),     64'd4);
    chk("s2 entry0",  64'(entry(0)),      64'd30);

    // Start with nothing valid is ignored.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    chk("empty mask", 64'(bus.validMask), 64'd0);
    bus.strmStart = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("empty start%0d", k), 64'(bus.strmValid), 64'd0);
    end
    bus.strmStart = 1'b0;

    // Asynchronous reset after the first beat abandons the stream.
    setup_134();
    bus.strmStart = 1'b1;
    sb.push_back(bt(3'd1, 32'd21, 1'b0));
    @(negedge clk);
    bus.strmStart = 1'b0;
    pop_cmp("r b1");
    @(negedge clk);
    chk("r pre idx", 64'(bus.strmIdx), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("r mask",   64'(bus.validMask),    64'd0);
    chk("r count",  64'(bus.count),        64'd0);
    chk("r full",   64'(bus.full),         64'd0);
    chk("r wrErr",  64'(bus.wrErr),        64'd0);
    chk("r valid",  64'(bus.strmValid),    64'd0);
    chk("r idx",    64'(bus.strmIdx),      64'd0);
    chk("r last",   64'(bus.strmLast),     64'd0);
    chk("r sdata",  64'(bus.strmData),     64'd0);
    chk("r rdData", 64'(bus.rdData == '0), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("r post%0d valid", k), 64'(bus.strmValid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
